// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the NAND SR latch driver.
package sr_drv_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StPulse,
        StDead,
        StCheck,
        StDone
    } state_e;

    typedef enum logic {
        OP_SET,
        OP_CLR
    } op_e;

    localparam int unsigned PULSE_W_MIN = 1;
    localparam int unsigned DEAD_W_MIN  = 3;

    function automatic int unsigned cnt_width(input int unsigned pulse_w,
                                              input int unsigned dead_w);
        int unsigned longest;
        longest = (pulse_w > dead_w) ? pulse_w : dead_w;
        return $clog2(longest + 1);
    endfunction

    function automatic logic expected_q(input op_e op);
        return (op == OP_SET);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to RST_VAL.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a NAND SR latch with timed, mutually exclusive active-low pulses
// and checks the synchronised readback after a dead time.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned DEAD_W  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int unsigned CW = cnt_width(PULSE_W, DEAD_W);

    if (PULSE_W < PULSE_W_MIN || DEAD_W < DEAD_W_MIN) begin : g_param_check
        $error("sr_latch_driver: PULSE_W must be >= 1 and DEAD_W must be >= 3");
    end

    state_e          r_state;
    op_e             r_op;
    logic            r_init;
    logic [CW-1:0]   r_cnt;
    logic            r_s_n;
    logic            r_r_n;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            w_q_sync;

    sync2 #(
        .RST_VAL (1'b0)
    ) u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (q_fb),
        .o_q   (w_q_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StInit;
            r_op    <= OP_CLR;
            r_init  <= 1'b1;
            r_cnt   <= '0;
            r_s_n   <= 1'b1;
            r_r_n   <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StInit: begin
                    r_op    <= OP_CLR;
                    r_init  <= 1'b1;
                    r_cnt   <= CW'(PULSE_W - 1);
                    r_r_n   <= 1'b0;
                    r_state <= StPulse;
                end
                StIdle: begin
                    // Clear wins when both strobes arrive together.
                    if (set_req || clr_req) begin
                        r_op    <= clr_req ? OP_CLR : OP_SET;
                        r_init  <= 1'b0;
                        r_cnt   <= CW'(PULSE_W - 1);
                        r_s_n   <= clr_req;
                        r_r_n   <= !clr_req;
                        r_busy  <= 1'b1;
                        r_state <= StPulse;
                    end
                end
                StPulse: begin
                    if (r_cnt == '0) begin
                        r_s_n   <= 1'b1;
                        r_r_n   <= 1'b1;
                        r_cnt   <= CW'(DEAD_W - 1);
                        r_state <= StDead;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDead: begin
                    if (r_cnt == '0) begin
                        r_state <= StCheck;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StCheck: begin
                    r_err <= (w_q_sync != expected_q(r_op));
                    // The power-up clear returns straight to idle without a done pulse.
                    if (r_init) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_s_n   <= 1'b1;
                    r_r_n   <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= StInit;
                end
            endcase
        end
    end

    assign s_n  = r_s_n;
    assign r_n  = r_r_n;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver driving a behavioural NAND SR latch.
module tb_sr_latch_driver;

    localparam int PW   = 2;
    localparam int DW   = 3;
    localparam int MAXC = 8000;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic stuck   = 1'b0;
    logic lat_q   = 1'b1;
    logic q_fb;
    logic s_n;
    logic r_n;
    logic busy;
    logic done;
    logic err;

    sr_latch_driver #(
        .PULSE_W (PW),
        .DEAD_W  (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .clr_req (clr_req),
        .q_fb    (q_fb),
        .s_n     (s_n),
        .r_n     (r_n),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // Latch load: a low s_n sets q, a low r_n clears it, otherwise q holds.
    always @(s_n or r_n) begin
        if (s_n === 1'b0) lat_q = 1'b1;
        else if (r_n === 1'b0) lat_q = 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : lat_q;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit exp_sn   [MAXC];
    bit exp_rn   [MAXC];
    bit exp_busy [MAXC];
    bit exp_err  [MAXC];

    typedef struct {
        int cyc;
        bit err;
        bit q;
    } exp_t;
    exp_t sb[$];

    int free_at = MAXC;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, req);
        end
    endtask

    task automatic model_reset_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            exp_sn[i]   = 1'b1;
            exp_rn[i]   = 1'b1;
            exp_busy[i] = 1'b1;
            exp_err[i]  = 1'b0;
        end
        sb.delete();
        free_at = MAXC;
    endtask

    // Release in cycle rel: clear pulse, dead time, check, then idle with err=0.
    task automatic model_init(input int rel);
        for (int i = rel + 1; i < MAXC; i++) begin
            exp_sn[i]   = 1'b1;
            exp_rn[i]   = !(i <= rel + PW);
            exp_busy[i] = (i <= rel + PW + DW + 1);
            exp_err[i]  = 1'b0;
        end
        free_at = rel + PW + DW + 2;
    endtask

    task automatic model_accept(input int k, input bit is_clr);
        exp_t e;
        e.cyc = k + PW + DW + 2;
        e.err = stuck && !is_clr;
        e.q   = !is_clr;
        for (int i = k + 1; i <= k + PW && i < MAXC; i++) begin
            if (is_clr) exp_rn[i] = 1'b0;
            else exp_sn[i] = 1'b0;
        end
        for (int i = k + 1; i <= e.cyc && i < MAXC; i++) exp_busy[i] = 1'b1;
        for (int i = e.cyc; i < MAXC; i++) exp_err[i] = e.err;
        sb.push_back(e);
        free_at = e.cyc + 1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input bit s, input bit c);
        set_req = s;
        clr_req = c;
        if ((s || c) && cyc >= free_at) model_accept(cyc, c);
        step();
        set_req = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < free_at) step();
    endtask

    // Monitor: per-cycle drive/busy/err checks, scoreboard pop on each done pulse.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            check("s_n", s_n, exp_sn[cyc]);
            check("r_n", r_n, exp_rn[cyc]);
            check("busy", busy, exp_busy[cyc]);
            check("err_level", err, exp_err[cyc]);
            check("both_low", (s_n === 1'b0 && r_n === 1'b0), 0);
            if (done === 1'b1) begin
                check("done_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("done_err", err, e.err);
                    check("done_latch_q", lat_q, e.q);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("done_pulse", done, 1);
            end
        end
    end

    initial begin
        #(10 * MAXC - 100);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int rel;
        int k;
        model_reset_from(0);
        while (cyc < 2) step();
        rst_n = 1'b1;
        rel = cyc;
        model_init(rel);
        while (cyc < rel + 8) step();
        check("init_latch_q", lat_q, 0);

        while (cyc < 20) step();
        issue(1'b1, 1'b0);
        wait_idle();
        check("set_latch_q", lat_q, 1);

        issue(1'b1, 1'b1);
        wait_idle();
        check("both_req_latch_q", lat_q, 0);

        stuck = 1'b1;
        issue(1'b1, 1'b0);
        wait_idle();
        issue(1'b0, 1'b1);
        wait_idle();
        stuck = 1'b0;

        // Re-strobes during the pulse and the dead time must be dropped.
        issue(1'b1, 1'b0);
        issue(1'b1, 1'b0);
        step();
        step();
        issue(1'b1, 1'b0);
        wait_idle();

        issue(1'b0, 1'b1);
        wait_idle();
        issue(1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("pulse_active_s_n", s_n, 0);
        rst_n = 1'b0;
        model_reset_from(cyc);
        #1;
        check("async_reset_s_n", s_n, 1);
        check("async_reset_r_n", r_n, 1);
        check("async_reset_busy", busy, 1);
        step();
        step();
        rst_n = 1'b1;
        k = cyc;
        model_init(k);
        while (cyc < k + 8) step();
        check("reinit_latch_q", lat_q, 0);

        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = $urandom_range(0, 8);
            repeat (gap) step();
            if (cyc >= free_at && $urandom_range(0, 3) == 0) stuck = 1'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        repeat (3) step();
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous controller that writes a NAND SR latch through its active-low set/reset inputs.
- Converts single-cycle set/clear requests into timed, mutually exclusive active-low pulses, followed by a dead time.
- Reads the latch output back through a synchroniser and flags a write that did not take.
- Sits between clocked control logic and any cross-coupled NAND latch; guarantees the latch's invalid input (both inputs low) is never driven.

Parameters:
- PULSE_W, 2, cycles the selected active-low input is held low; legal range >= 1.
- DEAD_W, 3, cycles both inputs are held high after a pulse before the readback check; legal range >= 3, which covers synchroniser latency plus margin.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- set_req  in  1  single-cycle strobe requesting q=1.
- clr_req  in  1  single-cycle strobe requesting q=0.
- q_fb  in  1  latch q output, asynchronous to clk.
- s_n  out  1  active-low set drive to the latch; idle 1.
- r_n  out  1  active-low reset drive to the latch; idle 1.
- busy  out  1  high while an operation, including the init clear, is in progress.
- done  out  1  one-cycle pulse when a requested operation completes.
- err  out  1  readback mismatch result of the last completed operation.

Behaviour:
- Reset (rst_n=0, asynchronous): s_n=1, r_n=1, busy=1, done=0, err=0, counter=0, synchroniser flops=0, state=INIT.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: INIT, IDLE, PULSE, DEAD, CHECK, DONE.
- INIT: entered from reset. Performs one clear operation (PULSE, DEAD, CHECK) with expected q=0. Does not pulse done. Updates err.
- IDLE: busy=0, both drives high.
  - Request accepted on the edge where set_req or clr_req is sampled high.
  - Both sampled high in the same cycle: clear wins and the set is discarded.
  - Requests sampled while busy=1 are ignored, not queued.
- PULSE: exactly one of s_n/r_n low, for PULSE_W cycles.
  - After the accept edge, cycles 1..PULSE_W are low.
  - s_n and r_n are never both 0 in any cycle, including across state transitions.
- DEAD: both high for DEAD_W cycles.
- CHECK: one cycle. Compare the synchronised q_fb with expected (1 for set, 0 for clear). err <= mismatch.
- DONE: one cycle. done=1, busy=1. Next state IDLE, where a new request can be accepted.
- Timing for one operation from the accept edge:
  - busy=1 for PULSE_W+DEAD_W+2 cycles.
  - done occurs in cycle PULSE_W+DEAD_W+2.
- err holds its value until the next CHECK overwrites it.
- q_fb passes through a 2-flop synchroniser (reset value 0) before any use.
- Counter is sized to clog2(max(PULSE_W,DEAD_W)+1) bits, counts down, and reloads on each state entry.
  - No wrap-around is possible within a phase.
- Reset asserted mid-pulse: s_n and r_n go to 1 immediately (asynchronously). The in-flight operation is abandoned and the INIT clear reruns after release.
- Illegal parameter values are caught by an elaboration-time check.

Decomposition:
- Shared package sr_drv_pkg:
  - State enum covering the six states.
  - Op type: OP_SET, OP_CLR.
  - Minimum-legal constants PULSE_W_MIN=1 and DEAD_W_MIN=3.
- One sub-module: sync2, a 2-flop synchroniser with async active-low reset and a reset value parameter.
- The benches instantiate the existing gate-level NAND latch as the load, with q_fb tied to its q.

Test Plan:
- Reset release, default params, NAND latch load:
  - r_n low for exactly 2 cycles, then both high for 3 cycles.
  - busy falls 7 cycles after release.
  - No done pulse; err=0; latch q=0.
- set_req strobe at cycle 20:
  - s_n low in cycles 21-22, both high in cycles 23-25, CHECK in cycle 26.
  - done=1 in cycle 27; err=0; latch q=1.
- set_req and clr_req high together in IDLE:
  - Only r_n pulses; s_n stays 1 throughout; final q=0.
- q_fb forced stuck at 0, then set_req:
  - done pulse arrives with err=1.
  - A subsequent clr_req with q_fb still stuck at 0 gives err=0.
- set_req strobed again during PULSE and during DEAD: ignored, only one done pulse.
- rst_n asserted during the s_n-low pulse:
  - s_n=1 the same cycle, without waiting for a clock edge.
  - After release, the INIT clear sequence repeats.
- Assertion across all tests: never (s_n==0 && r_n==0).
